instr_fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of the program counter. It takes the current fetch address and issues it to instruction memory over a request/grant port. It pairs each in-order response with its address in a small in-order buffer and presents `{pc, instruction}` to decode over a valid/ready handshake. On a taken jump or branch, a redirect flushes all buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_buffer.sv | 71 +++++++
 rtl/instr_fetch_unit.sv | 85 ++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order slot buffer pairing fetch addresses with their memory responses.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RST_INSTR = NOP,
  localparam int         PW        = $clog2(DEPTH),
  localparam int         CW        = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc,
  input  logic [31:0]   alloc_pc,
  input  logic          fill,
  input  logic [31:0]   fill_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_slot_t   rd_slot,
  output logic [CW-1:0] alloc_cnt,
  output logic [CW-1:0] unfilled_cnt
);

  fetch_slot_t   slots [DEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] rd_ptr;

  assign rd_slot = slots[rd_ptr];

  // Pop, fill and alloc never target the same slot in one cycle: fill only
  // hits unfilled slots, pop only filled ones, and alloc only free ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '{pc: 32'h0, instr: RST_INSTR, filled: 1'b0};
      end
      alloc_ptr    <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i].filled <= 1'b0;
      end
      alloc_ptr    <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
    end else begin
      if (pop) begin
        slots[rd_ptr].filled <= 1'b0;
        rd_ptr               <= rd_ptr + PW'(1);
      end
      if (fill) begin
        slots[fill_ptr].instr  <= fill_data;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PW'(1);
      end
      if (alloc) begin
        slots[alloc_ptr].pc     <= alloc_pc;
        slots[alloc_ptr].filled <= 1'b0;
        alloc_ptr               <= alloc_ptr + PW'(1);
      end
      alloc_cnt    <= alloc_cnt + CW'(alloc) - CW'(pop);
      unfilled_cnt <= unfilled_cnt + CW'(alloc) - CW'(fill);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues PC to instruction memory, buffers in-order responses,
// presents {pc, instr} to decode, and flushes on redirect.
module instr_fetch_unit #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = fetch_pkg::NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_slot_t   rd_slot;
  logic [CW-1:0] alloc_cnt;
  logic [CW-1:0] unfilled_cnt;
  logic [CW-1:0] discard_cnt;
  logic [CW:0]   occupancy;
  logic          boot;
  logic          credit;
  logic          fill;
  logic          pop;

  // Credit counts slots plus responses still owed to flushed requests, so a
  // stale response can never land on a freshly allocated slot.
  assign occupancy = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
  assign credit    = occupancy < (CW+1)'(DEPTH);

  assign imem_req  = pc_valid & credit & ~redirect & ~reset & ~boot;
  assign imem_addr = pc_in;
  assign pc_ready  = imem_req & imem_gnt;

  assign fill        = imem_rvalid & (discard_cnt == '0) & ~redirect;
  assign instr_valid = rd_slot.filled & (alloc_cnt != '0) & ~redirect;
  assign pop         = instr_valid & instr_ready;
  assign instr_out   = rd_slot.instr;
  assign instr_pc    = rd_slot.pc;

  // Holds requests off for the first cycle after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) boot <= 1'b1;
    else       boot <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard_cnt <= '0;
    end else if (redirect) begin
      discard_cnt <= discard_cnt + unfilled_cnt - CW'(imem_rvalid);
    end else if (imem_rvalid && (discard_cnt != '0)) begin
      discard_cnt <= discard_cnt - CW'(1);
    end
  end

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .RST_INSTR(NOP)
  ) u_buffer (
    .clk         (clk),
    .reset       (reset),
    .alloc       (pc_ready),
    .alloc_pc    (pc_in),
    .fill        (fill),
    .fill_data   (imem_rdata),
    .pop         (pop),
    .flush       (redirect),
    .rd_slot     (rd_slot),
    .alloc_cnt   (alloc_cnt),
    .unfilled_cnt(unfilled_cnt)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a queue-based model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    bit          filled;
  } ent_t;

  req_t        pend[$];
  ent_t        expq[$];
  int          pop_cyc[$];
  logic [31:0] pop_pc[$];
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          total = 0;
  int          bad = 0;
  bit          boot_ref = 1'b0;
  bit          last_grant = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit rv, exp_req, exp_valid;
    int stale_n, due;
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? memf(pend[0].addr) : 32'hDEADBEEF;
    stale_n = 0;
    foreach (pend[i]) if (pend[i].stale) stale_n++;
    exp_req   = pc_valid && !redirect && !boot_ref && ((expq.size() + stale_n) < DEPTH);
    exp_valid = !redirect && (expq.size() > 0) && expq[0].filled;
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("pc_ready", {31'b0, pc_ready}, {31'b0, exp_req & imem_gnt});
    chk("imem_addr", imem_addr, pc_in);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("instr_pc", instr_pc, expq[0].pc);
      chk("instr_out", instr_out, memf(expq[0].pc));
    end
    last_grant = exp_req && imem_gnt;
    if (exp_valid && instr_ready) begin
      pop_cyc.push_back(cyc);
      pop_pc.push_back(expq[0].pc);
      void'(expq.pop_front());
    end
    if (rv) begin
      if (!pend[0].stale && !redirect) begin
        for (int i = 0; i < expq.size(); i++) begin
          if (!expq[i].filled) begin
            expq[i].filled = 1'b1;
            break;
          end
        end
      end
      void'(pend.pop_front());
    end
    if (redirect) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      expq.delete();
    end else if (last_grant) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      pend.push_back('{addr: pc_in, due: due, stale: 1'b0});
      expq.push_back('{pc: pc_in, filled: 1'b0});
    end
    @(posedge clk);
    #1;
    cyc++;
    boot_ref = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    pc_valid    = 1'b1;
    imem_gnt    = 1'b1;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr_out", instr_out, 32'h00000013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_pc_ready", {31'b0, pc_ready}, 32'h0);
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    pend.delete();
    expq.delete();
    last_due = 0;
    boot_ref = 1'b1;
  endtask

  task automatic drain(input int n);
    pc_valid = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b1;
    imem_gnt = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          first, granted, c0, g;
    logic [31:0] pc;
    pc_in = 32'h0;
    instr_ready = 1'b1;
    do_reset();
    tick();

    // Streaming, L = 1
    lat = 1; imem_gnt = 1'b1; instr_ready = 1'b1; pc_valid = 1'b1;
    pc = 32'h0; first = -1; granted = 0;
    pop_cyc.delete(); pop_pc.delete();
    for (int k = 0; k < 20 && granted < 4; k++) begin
      pc_in = pc;
      tick();
      if (last_grant) begin
        if (first < 0) first = cyc - 1;
        pc += 4;
        granted++;
      end
    end
    drain(5);
    chk("stream_pops", pop_cyc.size(), 4);
    for (int k = 0; k < 4 && k < pop_cyc.size(); k++) begin
      chk("stream_cyc", pop_cyc[k], first + 2 + k);
      chk("stream_pc", pop_pc[k], 4 * k);
    end

    // Backpressure
    instr_ready = 1'b0; pc_valid = 1'b1; pc = 32'h40; granted = 0;
    for (int k = 0; k < 5; k++) begin
      pc_in = pc;
      tick();
      if (last_grant) begin
        pc += 4;
        granted++;
      end
    end
    chk("bp_grants", granted, 4);
    chk("bp_5th_grant", {31'b0, last_grant}, 32'h0);
    pop_cyc.delete(); pop_pc.delete();
    c0 = cyc;
    drain(6);
    chk("bp_pops", pop_cyc.size(), 4);
    for (int k = 0; k < 4 && k < pop_cyc.size(); k++) begin
      chk("bp_cyc", pop_cyc[k], c0 + k);
      chk("bp_pc", pop_pc[k], 32'h40 + 4 * k);
    end

    // Redirect with two in-flight requests, L = 3
    lat = 3; pc_valid = 1'b1;
    pc_in = 32'h10; tick();
    pc_in = 32'h14; tick();
    redirect = 1'b1; pc_in = 32'h100; tick();
    redirect = 1'b0; tick();
    pop_pc.delete();
    drain(10);
    chk("redir_pops", pop_pc.size(), 1);
    if (pop_pc.size() > 0) chk("redir_first_pc", pop_pc[0], 32'h100);

    // Redirect coinciding with the only outstanding response, L = 2
    lat = 2; pc_valid = 1'b1;
    pc_in = 32'h20; tick();
    pc_valid = 1'b0; tick();
    redirect = 1'b1; pc_in = 32'h200; tick();
    redirect = 1'b0; pc_valid = 1'b1; g = cyc; tick();
    pop_pc.delete(); pop_cyc.delete();
    drain(6);
    chk("rr_pops", pop_pc.size(), 1);
    if (pop_pc.size() > 0) begin
      chk("rr_pc", pop_pc[0], 32'h200);
      chk("rr_cyc", pop_cyc[0], g + 3);
    end

    // Grant stall
    lat = 1; imem_gnt = 1'b0; pc_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc_in = $urandom;
      tick();
      chk("stall_pc_ready", {31'b0, pc_ready}, 32'h0);
    end
    imem_gnt = 1'b1; pc_in = 32'h300; tick();
    pop_pc.delete();
    drain(6);
    chk("stall_pops", pop_pc.size(), 1);
    if (pop_pc.size() > 0) chk("stall_pc", pop_pc[0], 32'h300);

    // Randomized traffic
    pc = 32'h1000;
    for (int k = 0; k < 800; k++) begin
      pc_valid    = ($urandom_range(0, 3) != 0);
      imem_gnt    = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      lat         = $urandom_range(1, 4);
      if (redirect) pc = {$urandom_range(0, 65535), 2'b00};
      pc_in = pc;
      tick();
      if (last_grant || redirect) pc += 4;
    end
    drain(20);

    // Reset mid-stream with two filled slots
    lat = 1; instr_ready = 1'b0; pc_valid = 1'b1; imem_gnt = 1'b1;
    pc_in = 32'h500; tick();
    pc_in = 32'h504; tick();
    pc_valid = 1'b0; tick(); tick();
    do_reset();
    pc_in = 32'h600; instr_ready = 1'b1;
    tick();
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
